// File: rtl/banked_dp_ram_if.sv
// Bus bundle for banked_dp_ram: write port, read port, clear request and status.
// Master drives requests; slave (the RAM) returns read data, strobe and busy.
interface banked_dp_ram_if #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_SIZE  = 12
);
    logic                  clr;
    logic                  wr_en;
    logic [ADDR_SIZE-1:0]  wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic [ADDR_SIZE-1:0]  rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  init_busy;

    modport master (
        output clr, wr_en, wr_addr, wr_data, rd_en, rd_addr,
        input  rd_data, rd_valid, init_busy
    );

    modport slave (
        input  clr, wr_en, wr_addr, wr_data, rd_en, rd_addr,
        output rd_data, rd_valid, init_busy
    );
endinterface

// File: rtl/banked_dp_ram.sv
// Banked simple-dual-port RAM with hardware clear FSM, read-valid strobe and defined collisions.
// Optional feature macro: COLLISION_BYPASS_EN (write-first forwarding; default read-first).
module banked_dp_ram #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned IDX_BITS   = 10,
    parameter int unsigned SEL_BITS   = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    banked_dp_ram_if.slave bus
);
    localparam int unsigned ADDR_SIZE  = IDX_BITS + SEL_BITS;
    localparam int unsigned NUM_BANKS  = 2 ** SEL_BITS;
    localparam int unsigned BANK_DEPTH = 2 ** IDX_BITS;

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e                state_q;
    state_e                state_d;
    logic [IDX_BITS-1:0]   init_cnt_q;
    logic [IDX_BITS-1:0]   init_cnt_d;

    logic                  init_we_c;
    logic                  wr_fire_c;
    logic                  rd_fire_c;

    logic [SEL_BITS-1:0]   wr_sel_c;
    logic [SEL_BITS-1:0]   rd_sel_c;
    logic [IDX_BITS-1:0]   wr_idx_c;
    logic [IDX_BITS-1:0]   rd_idx_c;
    logic [NUM_BANKS-1:0]  wr_bank_oh_c;
    logic [NUM_BANKS-1:0]  rd_bank_oh_c;

    logic [NUM_BANKS-1:0]  rd_sel_oh_q;
    logic                  rd_valid_q;

    logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] bank_out_c;
    logic [DATA_WIDTH-1:0]                rd_mux_c;

    // Address split: MSBs select the bank, LSBs index within it
    assign wr_sel_c     = bus.wr_addr[ADDR_SIZE-1 -: SEL_BITS];
    assign rd_sel_c     = bus.rd_addr[ADDR_SIZE-1 -: SEL_BITS];
    assign wr_idx_c     = bus.wr_addr[IDX_BITS-1:0];
    assign rd_idx_c     = bus.rd_addr[IDX_BITS-1:0];
    assign wr_bank_oh_c = NUM_BANKS'(1) << wr_sel_c;
    assign rd_bank_oh_c = NUM_BANKS'(1) << rd_sel_c;

    // Clear FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_INIT;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    // Clear FSM next state and port gating; clr always restarts the sweep from index 0
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        init_we_c  = 1'b0;
        wr_fire_c  = 1'b0;
        rd_fire_c  = 1'b0;
        unique case (state_q)
            S_INIT: begin
                init_we_c = 1'b1;
                if (bus.clr) begin
                    init_cnt_d = '0;
                end else if (init_cnt_q == IDX_BITS'(BANK_DEPTH - 1)) begin
                    state_d    = S_RUN;
                    init_cnt_d = '0;
                end else begin
                    init_cnt_d = init_cnt_q + IDX_BITS'(1);
                end
            end
            S_RUN: begin
                wr_fire_c = bus.wr_en;
                rd_fire_c = bus.rd_en;
                if (bus.clr) begin
                    state_d    = S_INIT;
                    init_cnt_d = '0;
                end
            end
            default: begin
                state_d    = S_INIT;
                init_cnt_d = '0;
            end
        endcase
    end

    // Per-bank storage and read register; the init sweep hits every bank in parallel
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [DATA_WIDTH-1:0] mem_q [BANK_DEPTH];
        logic [DATA_WIDTH-1:0] rd_q;

        always_ff @(posedge clk) begin
            if (init_we_c) begin
                mem_q[init_cnt_q] <= '0;
            end else if (wr_fire_c && wr_bank_oh_c[b]) begin
                mem_q[wr_idx_c] <= bus.wr_data;
            end
        end

        // Read-before-write: the same-edge write is not visible here
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_q <= '0;
            end else if (rd_fire_c && rd_bank_oh_c[b]) begin
                rd_q <= mem_q[rd_idx_c];
            end
        end

        assign bank_out_c[b] = rd_sel_oh_q[b] ? rd_q : '0;
    end

    // Registered one-hot bank select and read strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_sel_oh_q <= NUM_BANKS'(1);
            rd_valid_q  <= 1'b0;
        end else begin
            rd_valid_q <= rd_fire_c;
            if (rd_fire_c) begin
                rd_sel_oh_q <= rd_bank_oh_c;
            end
        end
    end

    // AND-OR output mux over the bank read registers
    always_comb begin
        rd_mux_c = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            rd_mux_c = rd_mux_c | bank_out_c[b];
        end
    end

`ifdef COLLISION_BYPASS_EN
    logic                  collide_c;
    logic                  collide_q;
    logic [DATA_WIDTH-1:0] fwd_data_q;

    assign collide_c = wr_fire_c && (bus.wr_addr == bus.rd_addr);

    // Capture the colliding write so the read returns the new word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            collide_q  <= 1'b0;
            fwd_data_q <= '0;
        end else if (rd_fire_c) begin
            collide_q  <= collide_c;
            fwd_data_q <= bus.wr_data;
        end
    end

    assign bus.rd_data = collide_q ? fwd_data_q : rd_mux_c;
`else
    assign bus.rd_data = rd_mux_c;
`endif

    assign bus.rd_valid  = rd_valid_q;
    assign bus.init_busy = (state_q == S_INIT);

endmodule

// File: tb/tb_banked_dp_ram.sv
// Self-checking bench for banked_dp_ram against a word-array reference model.
`timescale 1ns/1ps
module tb_banked_dp_ram;
    localparam int unsigned DW    = 64;
    localparam int unsigned IB    = 4;
    localparam int unsigned SB    = 2;
    localparam int unsigned AW    = IB + SB;
    localparam int unsigned NW    = 2 ** AW;
    localparam int          DEPTH = 2 ** IB;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    banked_dp_ram_if #(.DATA_WIDTH(DW), .ADDR_SIZE(AW)) bus ();

    banked_dp_ram #(.DATA_WIDTH(DW), .IDX_BITS(IB), .SEL_BITS(SB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference model: flat word array, remaining busy cycles, expected read outputs
    logic [DW-1:0] ref_mem [NW];
    logic [DW-1:0] exp_data;
    logic          exp_valid;
    int            init_left;
    int            vectors;
    int            miscompares;

    task automatic model_zero();
        for (int i = 0; i < NW; i++) ref_mem[i] = '0;
    endtask

    task automatic model_reset();
        model_zero();
        init_left = DEPTH;
        exp_data  = '0;
        exp_valid = 1'b0;
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            model_reset();
        end else if (init_left > 0) begin
            init_left = bus.clr ? DEPTH : init_left - 1;
            exp_valid = 1'b0;
        end else begin
            exp_valid = bus.rd_en;
            if (bus.rd_en) begin
                exp_data = ref_mem[bus.rd_addr];
`ifdef COLLISION_BYPASS_EN
                if (bus.wr_en && bus.wr_addr == bus.rd_addr) exp_data = bus.wr_data;
`endif
            end
            if (bus.wr_en) ref_mem[bus.wr_addr] = bus.wr_data;
            if (bus.clr) begin
                model_zero();
                init_left = DEPTH;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic re, input logic [AW-1:0] ra, input logic cl);
        bus.wr_en   = we;
        bus.wr_addr = wa;
        bus.wr_data = wd;
        bus.rd_en   = re;
        bus.rd_addr = ra;
        bus.clr     = cl;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 1'b0, '0, 1'b0);
    endtask

    function automatic logic [DW-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic test_reset();
        logic [AW-1:0] zaddr [3];
        zaddr[0] = 6'h00; zaddr[1] = 6'h1F; zaddr[2] = 6'h3F;
        rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'($urandom), AW'($urandom), rnd64(), 1'b1, AW'($urandom), 1'b0);
            tick();
            vectors++;
            if (bus.init_busy !== 1'b1 || bus.rd_valid !== 1'b0 || bus.rd_data !== '0) begin
                miscompares++;
                $display("FAIL reset_hold: busy=%b valid=%b data=%h want busy=1 valid=0 data=0",
                         bus.init_busy, bus.rd_valid, bus.rd_data);
            end
        end
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'($urandom), AW'($urandom), rnd64(), 1'($urandom), AW'($urandom), 1'b0);
            tick();
            vectors++;
            if (bus.init_busy !== (i < DEPTH - 1) || bus.init_busy !== (init_left > 0)
                || bus.rd_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL init_sweep cycle %0d: busy=%b valid=%b want busy=%b valid=0",
                         i, bus.init_busy, bus.rd_valid, (i < DEPTH - 1));
            end
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, '0, '0, 1'b1, zaddr[i], 1'b0);
            tick();
            vectors++;
            if (bus.rd_valid !== 1'b1 || bus.rd_data !== 64'h0) begin
                miscompares++;
                $display("FAIL init_zero addr %h: valid=%b data=%h want valid=1 data=0",
                         zaddr[i], bus.rd_valid, bus.rd_data);
            end
        end
        idle();
    endtask

    task automatic test_write_read();
        logic [AW-1:0] a [4];
        logic [DW-1:0] d [4];
        a[0] = 6'h00; a[1] = 6'h10; a[2] = 6'h20; a[3] = 6'h3F;
        for (int i = 0; i < 4; i++) begin
            d[i] = 64'hA5A5_0000_0000_0000 | DW'(i + 1);
            drive(1'b1, a[i], d[i], 1'b0, '0, 1'b0);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, '0, '0, 1'b1, a[i], 1'b0);
            tick();
            vectors++;
            if (bus.rd_valid !== 1'b1 || bus.rd_data !== d[i] || bus.rd_data !== exp_data) begin
                miscompares++;
                $display("FAIL write_read addr %h: valid=%b data=%h want valid=1 data=%h",
                         a[i], bus.rd_valid, bus.rd_data, d[i]);
            end
        end
        idle();
        tick();
        vectors++;
        if (bus.rd_valid !== 1'b0 || bus.rd_data !== d[3]) begin
            miscompares++;
            $display("FAIL read_hold: valid=%b data=%h want valid=0 data=%h",
                     bus.rd_valid, bus.rd_data, d[3]);
        end
    endtask

    task automatic test_collision();
        logic [DW-1:0] want;
        drive(1'b1, 6'h05, 64'h22, 1'b0, '0, 1'b0);
        tick();
        drive(1'b1, 6'h05, 64'h11, 1'b1, 6'h05, 1'b0);
        tick();
`ifdef COLLISION_BYPASS_EN
        want = 64'h11;
`else
        want = 64'h22;
`endif
        vectors++;
        if (bus.rd_valid !== 1'b1 || bus.rd_data !== want || bus.rd_data !== exp_data) begin
            miscompares++;
            $display("FAIL collision: valid=%b data=%h want valid=1 data=%h",
                     bus.rd_valid, bus.rd_data, want);
        end
        drive(1'b0, '0, '0, 1'b1, 6'h05, 1'b0);
        tick();
        vectors++;
        if (bus.rd_valid !== 1'b1 || bus.rd_data !== 64'h11) begin
            miscompares++;
            $display("FAIL collision_followup: valid=%b data=%h want valid=1 data=11",
                     bus.rd_valid, bus.rd_data);
        end
        idle();
    endtask

    task automatic test_same_bank();
        logic [DW-1:0] v12;
        logic [DW-1:0] v13;
        v12 = rnd64();
        v13 = rnd64();
        drive(1'b1, 6'h12, v12, 1'b0, '0, 1'b0);
        tick();
        drive(1'b1, 6'h13, v13, 1'b1, 6'h12, 1'b0);
        tick();
        vectors++;
        if (bus.rd_valid !== 1'b1 || bus.rd_data !== v12) begin
            miscompares++;
            $display("FAIL same_bank_read: valid=%b data=%h want valid=1 data=%h",
                     bus.rd_valid, bus.rd_data, v12);
        end
        drive(1'b0, '0, '0, 1'b1, 6'h13, 1'b0);
        tick();
        vectors++;
        if (bus.rd_valid !== 1'b1 || bus.rd_data !== v13) begin
            miscompares++;
            $display("FAIL same_bank_write: valid=%b data=%h want valid=1 data=%h",
                     bus.rd_valid, bus.rd_data, v13);
        end
        idle();
    endtask

    task automatic test_clr();
        logic [AW-1:0] a [5];
        for (int i = 0; i < 4; i++) begin
            a[i] = AW'($urandom);
            drive(1'b1, a[i], rnd64() | 64'h1, 1'b0, '0, 1'b0);
            tick();
        end
        a[4] = AW'($urandom);
        drive(1'b1, a[4], rnd64() | 64'h1, 1'b1, a[0], 1'b1);
        tick();
        vectors++;
        if (bus.init_busy !== 1'b1 || bus.rd_valid !== 1'b1 || bus.rd_data !== exp_data) begin
            miscompares++;
            $display("FAIL clr_entry: busy=%b valid=%b data=%h want busy=1 valid=1 data=%h",
                     bus.init_busy, bus.rd_valid, bus.rd_data, exp_data);
        end
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, a[i % 5], rnd64() | 64'h1, 1'b1, a[i % 5], 1'b0);
            tick();
            vectors++;
            if (bus.init_busy !== (i < DEPTH - 1) || bus.rd_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL clr_sweep cycle %0d: busy=%b valid=%b want busy=%b valid=0",
                         i, bus.init_busy, bus.rd_valid, (i < DEPTH - 1));
            end
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, '0, '0, 1'b1, a[i], 1'b0);
            tick();
            vectors++;
            if (bus.rd_valid !== 1'b1 || bus.rd_data !== 64'h0) begin
                miscompares++;
                $display("FAIL clr_cleared addr %h: valid=%b data=%h want valid=1 data=0",
                         a[i], bus.rd_valid, bus.rd_data);
            end
        end
        idle();
    endtask

    task automatic test_reset_mid_init();
        drive(1'b1, 6'h2A, 64'hDEAD_BEEF_0000_0007, 1'b0, '0, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b1, 6'h2A, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b0, '0, 1'b1);
        tick();
        idle();
        for (int i = 0; i < 7; i++) tick();
        // Async assertion between edges must clear the outputs immediately
        rst_n = 1'b0;
        drive(1'b0, '0, '0, 1'b1, 6'h2A, 1'b0);
        model_reset();
        #1;
        vectors++;
        if (bus.init_busy !== 1'b1 || bus.rd_valid !== 1'b0 || bus.rd_data !== 64'h0) begin
            miscompares++;
            $display("FAIL async_reset: busy=%b valid=%b data=%h want busy=1 valid=0 data=0",
                     bus.init_busy, bus.rd_valid, bus.rd_data);
        end
        tick();
        vectors++;
        if (bus.rd_valid !== 1'b0 || bus.rd_data !== 64'h0) begin
            miscompares++;
            $display("FAIL reset_read: valid=%b data=%h want valid=0 data=0",
                     bus.rd_valid, bus.rd_data);
        end
        rst_n = 1'b1;
        idle();
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            vectors++;
            if (bus.init_busy !== (i < DEPTH - 1)) begin
                miscompares++;
                $display("FAIL restart_sweep cycle %0d: busy=%b want %b",
                         i, bus.init_busy, (i < DEPTH - 1));
            end
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] wa;
        logic [AW-1:0] ra;
        for (int i = 0; i < 400; i++) begin
            wa = AW'($urandom);
            ra = ($urandom_range(0, 9) < 3) ? wa : AW'($urandom);
            drive(1'($urandom), wa, rnd64(), 1'($urandom), ra, ($urandom_range(0, 79) == 0));
            tick();
            vectors++;
            if (bus.init_busy !== (init_left > 0) || bus.rd_valid !== exp_valid
                || bus.rd_data !== exp_data) begin
                miscompares++;
                $display("FAIL random cycle %0d: busy=%b valid=%b data=%h want busy=%b valid=%b data=%h",
                         i, bus.init_busy, bus.rd_valid, bus.rd_data,
                         (init_left > 0), exp_valid, exp_data);
            end
        end
        idle();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        idle();
        test_reset();
        test_write_read();
        test_collision();
        test_same_bank();
        test_clr();
        test_reset_mid_init();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
